// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared board types, window geometry and bounds helper
package tetris_pkg;

    localparam int WINDOW_DIM = 4;
    localparam int COORD_W    = 8;

    // Board coordinate; signed so windows may hang off the left/top edges.
    typedef struct packed {
        logic signed [COORD_W-1:0] x;
        logic signed [COORD_W-1:0] y;
    } point_t;

    // [r][c] maps to board cell (y+r, x+c).
    typedef logic [WINDOW_DIM-1:0][WINDOW_DIM-1:0] board_window_t;

    function automatic logic in_board(input int x, input int y, input int width, input int height);
        return (x >= 0) && (x < width) && (y >= 0) && (y < height);
    endfunction

endpackage

// File: rtl/board_window_extract.sv
// rtl/board_window_extract.sv - combinational 4x4 window slice of the board (BOARD_MEM_OOB_WALL_EN)
module board_window_extract
    import tetris_pkg::*;
#(
    parameter int width_p  = 16,
    parameter int height_p = 32
) (
    input  logic [height_p-1:0][width_p-1:0] rows_i,
    input  point_t                           pt_i,
    output board_window_t                    window_o
);

    // Select each window row, then each column; cells off the board take the wall value.
    always_comb begin
        int                 yy;
        int                 xx;
        logic [width_p-1:0] row_sel;
        window_o = '0;
        for (int r = 0; r < WINDOW_DIM; r++) begin
            yy      = int'(pt_i.y) + r;
            row_sel = '0;
            for (int i = 0; i < height_p; i++) begin
                if (yy == i) row_sel = rows_i[i];
            end
            for (int c = 0; c < WINDOW_DIM; c++) begin
                xx = int'(pt_i.x) + c;
                if (in_board(xx, yy, width_p, height_p)) begin
                    for (int j = 0; j < width_p; j++) begin
                        if (xx == j) window_o[r][c] = row_sel[j];
                    end
                end else begin
`ifdef BOARD_MEM_OOB_WALL_EN
                    // Side and bottom walls read occupied; the open sky above stays empty.
                    window_o[r][c] = (yy >= 0);
`else
                    window_o[r][c] = 1'b0;
`endif
                end
            end
        end
    end

endmodule

// File: rtl/board_matrix_mem.sv
// rtl/board_matrix_mem.sv - occupancy board with sequenced 4x4 window writes (BOARD_MEM_OOB_WALL_EN)
module board_matrix_mem
    import tetris_pkg::*;
#(
    parameter int width_p  = 16,
    parameter int height_p = 32,
    parameter int debug_p  = 0
) (
    input  logic          clk_i,
    input  logic          reset_n_i,
    input  point_t        wr_addr_i,
    input  board_window_t wr_data_i,
    input  logic          wr_v_i,
    output logic          ready_o,
    input  logic          clear_i,
    input  point_t        rd_addr_i,
    output board_window_t rd_data_o
);

    localparam logic [1:0] eIDLE  = 2'd0;
    localparam logic [1:0] eWrite = 2'd1;
    localparam logic [1:0] eClear = 2'd2;

    logic [1:0]                       state_q, state_d;
    logic [1:0]                       row_cnt_q, row_cnt_d;
    point_t                           addr_q, addr_d;
    board_window_t                    data_q, data_d;
    logic [height_p-1:0][width_p-1:0] rows_q, rows_d;
    logic                             ready_q;

    // Next-state: accept requests in idle, write one window row per cycle, or clear in one cycle.
    always_comb begin
        int wy;
        int wx;
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        rows_d    = rows_q;
        wy        = 0;
        wx        = 0;
        case (state_q)
            eIDLE: begin
                if (clear_i) begin
                    state_d = eClear;
                end else if (wr_v_i) begin
                    addr_d    = wr_addr_i;
                    data_d    = wr_data_i;
                    row_cnt_d = 2'd0;
                    state_d   = eWrite;
                end
            end
            eWrite: begin
                // Off-board rows/columns never match an index, so they are silently dropped.
                wy = int'(addr_q.y) + int'(row_cnt_q);
                for (int i = 0; i < height_p; i++) begin
                    if (wy == i) begin
                        for (int c = 0; c < WINDOW_DIM; c++) begin
                            wx = int'(addr_q.x) + c;
                            for (int j = 0; j < width_p; j++) begin
                                if (wx == j) rows_d[i][j] = data_q[row_cnt_q][c];
                            end
                        end
                    end
                end
                row_cnt_d = row_cnt_q + 2'd1;
                if (row_cnt_q == 2'd3) state_d = eIDLE;
            end
            eClear: begin
                rows_d  = '0;
                state_d = eIDLE;
            end
            default: state_d = eIDLE;
        endcase
    end

    // State, board storage and the registered ready decode.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= eIDLE;
            row_cnt_q <= 2'd0;
            addr_q    <= '0;
            data_q    <= '0;
            rows_q    <= '0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            rows_q    <= rows_d;
            ready_q   <= (state_d == eIDLE);
        end
    end

    assign ready_o = ready_q;

    board_window_extract #(
        .width_p  (width_p),
        .height_p (height_p)
    ) u_rd_window (
        .rows_i   (rows_q),
        .pt_i     (rd_addr_i),
        .window_o (rd_data_o)
    );

endmodule

// File: tb/tb_board_matrix_mem.sv
// tb/tb_board_matrix_mem.sv - directed self-checking bench for board_matrix_mem
module tb_board_matrix_mem;
    import tetris_pkg::*;

    logic          clk = 1'b0;
    logic          reset_n_i;
    point_t        wr_addr_i;
    board_window_t wr_data_i;
    logic          wr_v_i;
    logic          ready_o;
    logic          clear_i;
    point_t        rd_addr_i;
    board_window_t rd_data_o;

    int n_cmp = 0;
    int n_bad = 0;

    board_matrix_mem #(.width_p(16), .height_p(32), .debug_p(0)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n_i),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i),
        .wr_v_i    (wr_v_i),
        .ready_o   (ready_o),
        .clear_i   (clear_i),
        .rd_addr_i (rd_addr_i),
        .rd_data_o (rd_data_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_rd(input int x, input int y);
        rd_addr_i.x = 8'(x);
        rd_addr_i.y = 8'(y);
    endtask

    task automatic read_win(input int x, input int y, output logic [15:0] w);
        @(negedge clk);
        set_rd(x, y);
        #1;
        w = rd_data_o;
    endtask

    task automatic read_row(input int y, output logic [15:0] row);
        @(negedge clk);
        for (int xs = 0; xs < 16; xs += 4) begin
            set_rd(xs, y);
            #1;
            row[xs+:4] = rd_data_o[0];
        end
    endtask

    // Returns at the falling edge just after the request was sampled.
    task automatic issue(input int x, input int y, input logic [15:0] d, input logic wv, input logic clr);
        @(negedge clk);
        wr_addr_i.x = 8'(x);
        wr_addr_i.y = 8'(y);
        wr_data_i   = d;
        wr_v_i      = wv;
        clear_i     = clr;
        @(negedge clk);
        wr_v_i  = 1'b0;
        clear_i = 1'b0;
    endtask

    task automatic wait_ready(input int budget, output int cycles);
        cycles = 0;
        while (!ready_o && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        if (!ready_o) check("ready_timeout", ready_o, 1);
    endtask

    task automatic write_blk(input int x, input int y, input logic [15:0] d);
        int cyc;
        issue(x, y, d, 1'b1, 1'b0);
        wait_ready(20, cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;
        int          cyc;
        reset_n_i = 1'b0;
        wr_addr_i = '0;
        wr_data_i = '0;
        wr_v_i    = 1'b0;
        clear_i   = 1'b0;
        rd_addr_i = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", ready_o, 1);
        read_win(0, 0, w);
        check("rst_win00", w, 16'h0000);
        read_win(14, 30, w);
`ifdef BOARD_MEM_OOB_WALL_EN
        check("rst_win_corner", w, 16'hFFCC);
`else
        check("rst_win_corner", w, 16'h0000);
`endif
        @(negedge clk);
        reset_n_i = 1'b1;

        // Basic write at origin and its latency.
        issue(0, 0, 16'h000F, 1'b1, 1'b0);
        check("w0_busy", ready_o, 0);
        wait_ready(20, cyc);
        check("w0_busy_cycles", cyc, 4);
        read_win(0, 0, w);
        check("w0_win00", w, 16'h000F);
        read_row(0, w);
        check("w0_row0", w, 16'h000F);
        read_row(1, w);
        check("w0_row1", w, 16'h0000);

        // Overwrite semantics: zeros clear previously set bits.
        write_blk(0, 5, 16'h000F);
        write_blk(4, 5, 16'h000F);
        write_blk(8, 5, 16'h000F);
        write_blk(12, 5, 16'h000F);
        read_row(5, w);
        check("ow_preload", w, 16'hFFFF);
        write_blk(4, 5, 16'h0000);
        read_row(5, w);
        check("ow_row5", w, 16'hFF0F);

        // Clipping at the bottom-right corner.
        write_blk(14, 30, 16'hFFFF);
        read_win(14, 30, w);
`ifdef BOARD_MEM_OOB_WALL_EN
        check("clip_win", w, 16'hFFFF);
`else
        check("clip_win", w, 16'h0033);
`endif
        read_row(30, w);
        check("clip_row30", w, 16'hC000);
        read_row(31, w);
        check("clip_row31", w, 16'hC000);
        read_row(0, w);
        check("clip_nowrap_row0", w, 16'h000F);
        read_row(1, w);
        check("clip_nowrap_row1", w, 16'h0000);
        read_win(0, -2, w);
        check("above_top_win", w, 16'h0F00);

        // Second request while busy is dropped.
        issue(8, 10, 16'h1111, 1'b1, 1'b0);
        @(negedge clk);
        wr_data_i = 16'h8888;
        wr_v_i    = 1'b1;
        @(negedge clk);
        wr_v_i = 1'b0;
        wait_ready(20, cyc);
        repeat (6) @(negedge clk);
        check("busy_ready_idle", ready_o, 1);
        read_row(10, w);
        check("busy_row10", w, 16'h0100);
        read_row(13, w);
        check("busy_row13", w, 16'h0100);

        // Clear has priority over a simultaneous write.
        issue(0, 0, 16'hFFFF, 1'b1, 1'b1);
        check("clr_busy", ready_o, 0);
        @(negedge clk);
        check("clr_ready_back", ready_o, 1);
        read_win(0, 0, w);
        check("clr_win00", w, 16'h0000);
        read_row(5, w);
        check("clr_row5", w, 16'h0000);
        read_win(14, 30, w);
`ifdef BOARD_MEM_OOB_WALL_EN
        check("clr_win_corner", w, 16'hFFCC);
`else
        check("clr_win_corner", w, 16'h0000);
`endif

        // Asynchronous reset in the middle of a write.
        issue(0, 20, 16'hFFFF, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        set_rd(0, 20);
        #1;
        check("ar_partial", rd_data_o, 16'h00FF);
        reset_n_i = 1'b0;
        #1;
        check("ar_ready", ready_o, 1);
        check("ar_cleared", rd_data_o, 16'h0000);
        @(negedge clk);
        reset_n_i = 1'b1;
        issue(0, 20, 16'h0001, 1'b1, 1'b0);
        wait_ready(20, cyc);
        check("ar_post_cycles", cyc, 4);
        read_win(0, 20, w);
        check("ar_post_win", w, 16'h0001);
        read_row(21, w);
        check("ar_post_row21", w, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
